// File: rtl/iob_uart_tester_master.sv
// Native-bus initiator that configures the tester UART, then moves single TX/RX bytes by polling.
// Optional macro UART_TESTER_TIMEOUT_EN bounds each poll loop to POLL_MAX reads.
module iob_uart_tester_master #(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 32,
  parameter int DIV            = 16,
  parameter int SOFTRESET_ADDR = 0,
  parameter int DIV_ADDR       = 1,
  parameter int TXDATA_ADDR    = 2,
  parameter int TXEN_ADDR      = 3,
  parameter int TXREADY_ADDR   = 4,
  parameter int RXDATA_ADDR    = 5,
  parameter int RXEN_ADDR      = 6,
  parameter int RXREADY_ADDR   = 7,
  parameter int POLL_MAX       = 1024
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                tx_valid,
  input  logic [7:0]          tx_data,
  output logic                tx_ready,
  input  logic                rx_req,
  output logic                rx_valid,
  output logic [7:0]          rx_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                timeout
);

  typedef enum logic [3:0] {
    RST_ASSERT, RST_DEASSERT, SET_DIV, TX_EN, RX_EN,
    IDLE, TX_POLL, TX_WRITE, RX_POLL, RX_READ
  } state_t;

  state_t              state, state_d;
  logic                done;
  logic                m_valid_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                wr_d;
  logic                rx_cap;
  logic                init_fin;
  logic [7:0]          tx_byte;

  // Only rdata bit 0 (polls) and byte 0 (RX data) carry meaning.
  logic unused_bits;
  assign unused_bits = ^{m_rdata[DATA_W-1:8], POLL_MAX != 0};

  assign done = m_valid && m_ready;

`ifdef UART_TESTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);
  logic [CNT_W-1:0] poll_cnt, cnt_d;
  logic             poll_miss;
  logic             timeout_d;
`endif

  always_comb begin
    state_d  = state;
    rx_cap   = 1'b0;
    init_fin = 1'b0;
`ifdef UART_TESTER_TIMEOUT_EN
    poll_miss = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = poll_cnt;
`endif
    case (state)
      RST_ASSERT:   if (done) state_d = RST_DEASSERT;
      RST_DEASSERT: if (done) state_d = SET_DIV;
      SET_DIV:      if (done) state_d = TX_EN;
      TX_EN:        if (done) state_d = RX_EN;
      RX_EN: if (done) begin
        state_d  = IDLE;
        init_fin = 1'b1;
      end
      IDLE: begin
        if (tx_valid)    state_d = TX_POLL;
        else if (rx_req) state_d = RX_POLL;
      end
      TX_POLL: if (done) begin
        if (m_rdata[0]) state_d = TX_WRITE;
`ifdef UART_TESTER_TIMEOUT_EN
        else poll_miss = 1'b1;
`endif
      end
      TX_WRITE: if (done) state_d = IDLE;
      RX_POLL: if (done) begin
        if (m_rdata[0]) state_d = RX_READ;
`ifdef UART_TESTER_TIMEOUT_EN
        else poll_miss = 1'b1;
`endif
      end
      RX_READ: if (done) begin
        state_d = IDLE;
        rx_cap  = 1'b1;
      end
      default: state_d = RST_ASSERT;
    endcase

`ifdef UART_TESTER_TIMEOUT_EN
    // Poll states are only entered from IDLE, so clearing there covers every entry.
    if (state == IDLE) begin
      cnt_d = '0;
    end else if (poll_miss) begin
      cnt_d = poll_cnt + 1'b1;
      if (cnt_d == POLL_LIM) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
      end
    end
`endif

    // Request fields follow the next state so they are stable from the first valid cycle.
    addr_d  = '0;
    wdata_d = '0;
    wr_d    = 1'b0;
    case (state_d)
      RST_ASSERT:   begin addr_d = ADDR_W'(SOFTRESET_ADDR); wdata_d = DATA_W'(1); wr_d = 1'b1; end
      RST_DEASSERT: begin addr_d = ADDR_W'(SOFTRESET_ADDR); wr_d = 1'b1; end
      SET_DIV:      begin addr_d = ADDR_W'(DIV_ADDR); wdata_d = DATA_W'(DIV); wr_d = 1'b1; end
      TX_EN:        begin addr_d = ADDR_W'(TXEN_ADDR); wdata_d = DATA_W'(1); wr_d = 1'b1; end
      RX_EN:        begin addr_d = ADDR_W'(RXEN_ADDR); wdata_d = DATA_W'(1); wr_d = 1'b1; end
      TX_POLL:      addr_d = ADDR_W'(TXREADY_ADDR);
      TX_WRITE:     begin addr_d = ADDR_W'(TXDATA_ADDR); wdata_d = {{(DATA_W-8){1'b0}}, tx_byte}; wr_d = 1'b1; end
      RX_POLL:      addr_d = ADDR_W'(RXREADY_ADDR);
      RX_READ:      addr_d = ADDR_W'(RXDATA_ADDR);
      default:      addr_d = '0;
    endcase
    // Dropping valid for the cycle after every completion gives the mandatory idle gap.
    m_valid_d = (state_d != IDLE) && !done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RST_ASSERT;
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      tx_ready  <= 1'b0;
      tx_byte   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state    <= state_d;
      m_valid  <= m_valid_d;
      m_addr   <= addr_d;
      m_wdata  <= wdata_d;
      m_wstrb  <= wr_d ? '1 : '0;
      tx_ready <= (state_d == IDLE);
      rx_valid <= rx_cap;
      if (state == IDLE && tx_valid) tx_byte <= tx_data;
      if (rx_cap) rx_data <= m_rdata[7:0];
      if (init_fin) init_done <= 1'b1;
    end
  end

`ifdef UART_TESTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      poll_cnt <= cnt_d;
      timeout  <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iob_uart_tester_master.sv
// Directed/randomized bench: a native-bus responder logs transactions and a transaction-level model predicts them.
module tb_iob_uart_tester_master;
  localparam int POLL_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_done, tx_ready, rx_valid, timeout;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        rx_req = 1'b0;
  logic [7:0]  rx_data;
  logic        m_valid;
  logic [2:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;

  always #5 clk = ~clk;

  iob_uart_tester_master #(.POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .timeout(timeout)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  bit          txrdy_q[$];
  bit          rxrdy_q[$];
  logic [31:0] rxdata_v = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          rx_pulses = 0;
  int          to_pulses = 0;
  logic [7:0]  rx_seen = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: ready one cycle after valid; poll answers come from queues (default ready), noisy upper bits.
  initial begin
    logic [31:0] r;
    m_ready = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) m_ready = 1'b0;
      else if (m_ready) m_ready = 1'b0;
      else if (m_valid) begin
        log_q.push_back('{m_addr, m_wdata, m_wstrb});
        r = $urandom();
        if (m_wstrb == 4'h0) begin
          if (m_addr == 3'd4) r[0] = (txrdy_q.size() > 0) ? txrdy_q.pop_front() : 1'b1;
          if (m_addr == 3'd7) r[0] = (rxrdy_q.size() > 0) ? rxrdy_q.pop_front() : 1'b1;
          if (m_addr == 3'd5) r = rxdata_v;
        end
        m_rdata = r;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_pulses++;
      rx_seen = rx_data;
    end
    if (timeout) to_pulses++;
  end

  // Bus protocol: request held stable until ready, then at least one idle cycle.
  logic        pv = 1'b0, pr = 1'b0;
  logic [38:0] preq = '0;
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) chk("bus hold", {m_valid, m_addr, m_wdata, m_wstrb}, {1'b1, preq});
      if (pv && pr)  chk("bus gap", m_valid, 1'b0);
      pv   = m_valid;
      pr   = m_ready;
      preq = {m_addr, m_wdata, m_wstrb};
    end
  end

  task automatic expect_w(input logic [2:0] a, input logic [31:0] d);
    exp_q.push_back('{a, d, 4'hF});
  endtask

  task automatic expect_r(input logic [2:0] a);
    exp_q.push_back('{a, 32'h0, 4'h0});
  endtask

  task automatic expect_init();
    expect_w(3'd0, 32'd1); expect_w(3'd0, 32'd0); expect_w(3'd1, 32'd16);
    expect_w(3'd3, 32'd1); expect_w(3'd6, 32'd1);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size())
        chk($sformatf("%s txn%0d", tag, i),
            64'({log_q[i].addr, log_q[i].wdata, log_q[i].wstrb}),
            64'({exp_q[i].addr, exp_q[i].wdata, exp_q[i].wstrb}));
  endtask

  task automatic wait_idle(input int n, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (log_q.size() >= n && tx_ready) ok = 1'b1;
    end
    chk({tag, " reached idle"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_init(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (init_done) ok = 1'b1;
    end
    chk({tag, " init_done"}, 64'(ok), 64'd1);
    chk({tag, " tx_ready"}, 64'(tx_ready), 64'd1);
  endtask

  task automatic do_tx(input logic [7:0] b, input int n, input string tag);
    txrdy_q.delete(); log_q.delete(); exp_q.delete();
    repeat (n) txrdy_q.push_back(1'b0);
    txrdy_q.push_back(1'b1);
    repeat (n + 1) expect_r(3'd4);
    expect_w(3'd2, {24'h0, b});
    @(negedge clk);
    tx_valid = 1'b1; tx_data = b;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk({tag, " first req"}, 64'({m_valid, tx_ready, m_addr, m_wstrb}), 64'({1'b1, 1'b0, 3'd4, 4'h0}));
    wait_idle(n + 2, tag);
    repeat (2) @(negedge clk);
    cmp_log(tag);
  endtask

  task automatic do_rx(input logic [31:0] d, input int n, input string tag);
    rxrdy_q.delete(); log_q.delete(); exp_q.delete();
    repeat (n) rxrdy_q.push_back(1'b0);
    rxrdy_q.push_back(1'b1);
    rxdata_v = d;
    repeat (n + 1) expect_r(3'd7);
    expect_r(3'd5);
    rx_pulses = 0;
    @(negedge clk);
    rx_req = 1'b1;
    @(posedge clk); #1;
    rx_req = 1'b0;
    wait_idle(n + 2, tag);
    @(negedge clk);
    chk({tag, " pulses"}, 64'(rx_pulses), 64'd1);
    chk({tag, " rx_seen"}, 64'(rx_seen), 64'(d[7:0]));
    repeat (3) @(negedge clk);
    chk({tag, " rx_data hold"}, 64'({rx_valid, rx_data}), 64'({1'b0, d[7:0]}));
    cmp_log(tag);
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;

    // Reset state
    #1;
    chk("reset outputs", 64'({init_done, tx_ready, rx_valid, rx_data, m_valid, m_addr, m_wdata, m_wstrb, timeout}), 64'd0);
    repeat (3) @(negedge clk);
    chk("reset outputs held", 64'({init_done, tx_ready, rx_valid, m_valid, m_wstrb, timeout}), 64'd0);

    // Init sequence
    expect_init();
    rst = 1'b1;
    wait_init("init");
    cmp_log("init");

    // Stray ready while idle is ignored
    log_q.delete();
    @(negedge clk);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray ready", 64'({log_q.size() == 0, m_valid, tx_ready}), 64'({1'b1, 1'b0, 1'b1}));

    // Directed and randomized TX / RX
    do_tx(8'h41, 2, "tx41");
    do_rx(32'hABCD_EF5A, 0, "rx5a");
    for (int i = 0; i < 4; i++) begin
      do_tx(8'($urandom_range(0, 255)), $urandom_range(0, 3), $sformatf("txr%0d", i));
      do_rx($urandom(), $urandom_range(0, 3), $sformatf("rxr%0d", i));
    end

    // TX wins over RX; RX runs after returning to IDLE
    b = 8'($urandom_range(0, 255));
    log_q.delete(); exp_q.delete(); txrdy_q.delete(); rxrdy_q.delete();
    rxdata_v = $urandom();
    expect_r(3'd4); expect_w(3'd2, {24'h0, b}); expect_r(3'd7); expect_r(3'd5);
    rx_pulses = 0;
    @(negedge clk);
    tx_valid = 1'b1; rx_req = 1'b1; tx_data = b;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (log_q.size() >= 3) ok = 1'b1;
    end
    chk("prio rx started", 64'(ok), 64'd1);
    rx_req = 1'b0;
    wait_idle(4, "prio");
    repeat (2) @(negedge clk);
    cmp_log("prio");
    chk("prio pulses", 64'({rx_pulses, rx_data}), 64'({32'd1, rxdata_v[7:0]}));

    // Reset mid-transaction in TX_POLL
    txrdy_q.delete();
    repeat (50) txrdy_q.push_back(1'b0);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h77;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (m_valid) ok = 1'b1;
      else @(negedge clk);
    end
    chk("mid reset saw valid", 64'(ok), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid reset outputs", 64'({init_done, tx_ready, rx_valid, rx_data, m_valid, m_addr, m_wdata, m_wstrb, timeout}), 64'd0);
    txrdy_q.delete();
    repeat (3) @(negedge clk);
    log_q.delete(); exp_q.delete();
    expect_init();
    rst = 1'b1;
    wait_init("reinit");
    cmp_log("reinit");

`ifdef UART_TESTER_TIMEOUT_EN
    // Poll timeout with TXREADY stuck low
    log_q.delete(); exp_q.delete(); txrdy_q.delete();
    repeat (20) txrdy_q.push_back(1'b0);
    repeat (POLL_MAX) expect_r(3'd4);
    to_pulses = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h99;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_idle(POLL_MAX, "tmo");
    repeat (5) @(negedge clk);
    chk("tmo pulses", 64'(to_pulses), 64'd1);
    chk("tmo tx_ready", 64'({tx_ready, m_valid}), 64'({1'b1, 1'b0}));
    cmp_log("tmo");
    txrdy_q.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
